// File: rtl/ramarb_pkg.sv
// Shared types for the two-master RAM arbiter: data-phase owner encoding,
// AHB transfer-type and transfer-size constants.
package ramarb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are ignored.
  function automatic logic is_request(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ramarb_hold.sv
// Per-master hold register: parks an address phase that lost arbitration and
// presents either the parked or the live request to the grant logic.
module ramarb_hold
  import ramarb_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic              HCLK_I,
  input  logic              HRESET_I,
  input  logic              live_req,
  input  logic [AWIDTH-1:0] live_addr,
  input  logic [2:0]        live_size,
  input  logic              live_write,
  input  logic              grant,
  output logic              pend,
  output logic              cand,
  output logic [AWIDTH-1:0] req_addr,
  output logic [2:0]        req_size,
  output logic              req_write
);

  logic [AWIDTH-1:0] hold_addr;
  logic [2:0]        hold_size;
  logic              hold_write;

  always_ff @(posedge HCLK_I or posedge HRESET_I) begin
    if (HRESET_I) begin
      pend       <= 1'b0;
      hold_addr  <= '0;
      hold_size  <= HSIZE_BYTE;
      hold_write <= 1'b0;
    end else if (grant) begin
      pend <= 1'b0;
    end else if (live_req && !pend) begin
      pend       <= 1'b1;
      hold_addr  <= live_addr;
      hold_size  <= live_size;
      hold_write <= live_write;
    end
  end

  // A parked request always wins over the master's live inputs.
  assign cand      = pend | live_req;
  assign req_addr  = pend ? hold_addr  : live_addr;
  assign req_size  = pend ? hold_size  : live_size;
  assign req_write = pend ? hold_write : live_write;

endmodule

// File: rtl/ahb_ram_arbiter.sv
// Two-master AHB-lite arbiter in front of a single-ported RAM. Fixed priority
// M1 > M0 by default; define RAMARB_RR_EN for round-robin on contention.
module ahb_ram_arbiter
  import ramarb_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic              HCLK_I,
  input  logic              HRESET_I,
  input  logic [1:0]        M0_HTRANS_I,
  input  logic [AWIDTH-1:0] M0_HADDR_I,
  input  logic [2:0]        M0_HSIZE_I,
  input  logic              M0_HWRITE_I,
  input  logic [31:0]       M0_HWDATA_I,
  output logic [31:0]       M0_HRDATA_O,
  output logic              M0_HREADY_O,
  output logic              M0_HRESP_O,
  input  logic [1:0]        M1_HTRANS_I,
  input  logic [AWIDTH-1:0] M1_HADDR_I,
  input  logic [2:0]        M1_HSIZE_I,
  input  logic              M1_HWRITE_I,
  input  logic [31:0]       M1_HWDATA_I,
  output logic [31:0]       M1_HRDATA_O,
  output logic              M1_HREADY_O,
  output logic              M1_HRESP_O,
  output logic              S_HSEL_O,
  output logic              S_HREADY_O,
  output logic [AWIDTH-1:0] S_HADDR_O,
  output logic [2:0]        S_HSIZE_O,
  output logic              S_HWRITE_O,
  output logic [31:0]       S_HWDATA_O,
  input  logic [31:0]       S_HRDATA_I,
  input  logic              S_HREADY_I,
  input  logic              S_HRESP_I,
  output logic [1:0]        DBG_DP_OWNER_O
);

  // Handshake: an address phase is taken from master x when Mx_HTRANS_I is
  // NONSEQ/SEQ and Mx_HREADY_O is high on the same rising edge; the RAM takes
  // an address when S_HSEL_O & S_HREADY_O, and ends a data phase on S_HREADY_I.
  owner_e dp_owner;
`ifdef RAMARB_RR_EN
  owner_e rr_last;
`endif

  logic              slave_free;
  logic              live0, live1;
  logic              pend0, pend1;
  logic              cand0, cand1;
  logic              gnt0, gnt1;
  logic [AWIDTH-1:0] addr0, addr1;
  logic [2:0]        size0, size1;
  logic              write0, write1;

  assign slave_free = (dp_owner == OWN_NONE) | S_HREADY_I;

  assign M0_HREADY_O = (!pend0 && dp_owner != OWN_M0) || (dp_owner == OWN_M0 && S_HREADY_I);
  assign M1_HREADY_O = (!pend1 && dp_owner != OWN_M1) || (dp_owner == OWN_M1 && S_HREADY_I);

  assign live0 = M0_HREADY_O & is_request(M0_HTRANS_I);
  assign live1 = M1_HREADY_O & is_request(M1_HTRANS_I);

  ramarb_hold #(.AWIDTH(AWIDTH)) u_hold0 (
    .HCLK_I, .HRESET_I,
    .live_req(live0), .live_addr(M0_HADDR_I), .live_size(M0_HSIZE_I), .live_write(M0_HWRITE_I),
    .grant(gnt0), .pend(pend0), .cand(cand0),
    .req_addr(addr0), .req_size(size0), .req_write(write0)
  );

  ramarb_hold #(.AWIDTH(AWIDTH)) u_hold1 (
    .HCLK_I, .HRESET_I,
    .live_req(live1), .live_addr(M1_HADDR_I), .live_size(M1_HSIZE_I), .live_write(M1_HWRITE_I),
    .grant(gnt1), .pend(pend1), .cand(cand1),
    .req_addr(addr1), .req_size(size1), .req_write(write1)
  );

  // Grants only while the RAM can accept an address; nothing issues during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (slave_free && !HRESET_I) begin
      if (cand0 && cand1) begin
`ifdef RAMARB_RR_EN
        if (rr_last == OWN_M1) gnt0 = 1'b1;
        else                   gnt1 = 1'b1;
`else
        gnt1 = 1'b1;
`endif
      end else begin
        gnt0 = cand0;
        gnt1 = cand1;
      end
    end
  end

  always_ff @(posedge HCLK_I or posedge HRESET_I) begin
    if (HRESET_I) begin
      dp_owner <= OWN_NONE;
`ifdef RAMARB_RR_EN
      rr_last  <= OWN_M1;
`endif
    end else begin
      if (slave_free) dp_owner <= gnt1 ? OWN_M1 : (gnt0 ? OWN_M0 : OWN_NONE);
`ifdef RAMARB_RR_EN
      if (slave_free && cand0 && cand1) rr_last <= gnt0 ? OWN_M0 : OWN_M1;
`endif
    end
  end

  assign S_HSEL_O   = gnt0 | gnt1;
  assign S_HREADY_O = slave_free;
  assign S_HADDR_O  = gnt1 ? addr1  : addr0;
  assign S_HSIZE_O  = gnt1 ? size1  : size0;
  assign S_HWRITE_O = gnt1 ? write1 : write0;

  always_comb begin
    case (dp_owner)
      OWN_M0:  S_HWDATA_O = M0_HWDATA_I;
      OWN_M1:  S_HWDATA_O = M1_HWDATA_I;
      default: S_HWDATA_O = 32'd0;
    endcase
  end

  assign M0_HRDATA_O    = S_HRDATA_I;
  assign M1_HRDATA_O    = S_HRDATA_I;
  assign M0_HRESP_O     = (dp_owner == OWN_M0) & S_HRESP_I;
  assign M1_HRESP_O     = (dp_owner == OWN_M1) & S_HRESP_I;
  assign DBG_DP_OWNER_O = dp_owner;

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Bench for ahb_ram_arbiter: byte-writable RAM slave model, directed timing
// cases, then two randomized pipelined masters checked against a word-array model.
module tb_ahb_ram_arbiter;
  import ramarb_pkg::*;

  logic        HCLK_I;
  logic        HRESET_I;
  logic [1:0]  htrans [2];
  logic [7:0]  haddr  [2];
  logic [2:0]  hsize  [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic        hready [2];
  logic        hresp  [2];
  logic        S_HSEL_O, S_HREADY_O, S_HWRITE_O;
  logic [7:0]  S_HADDR_O;
  logic [2:0]  S_HSIZE_O;
  logic [31:0] S_HWDATA_O, s_hrdata;
  logic        s_hready, s_hresp;
  logic [1:0]  dbg_owner;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ref_mem [64];

  ahb_ram_arbiter #(.AWIDTH(8)) dut (
    .HCLK_I(HCLK_I), .HRESET_I(HRESET_I),
    .M0_HTRANS_I(htrans[0]), .M0_HADDR_I(haddr[0]), .M0_HSIZE_I(hsize[0]), .M0_HWRITE_I(hwrite[0]),
    .M0_HWDATA_I(hwdata[0]), .M0_HRDATA_O(hrdata[0]), .M0_HREADY_O(hready[0]), .M0_HRESP_O(hresp[0]),
    .M1_HTRANS_I(htrans[1]), .M1_HADDR_I(haddr[1]), .M1_HSIZE_I(hsize[1]), .M1_HWRITE_I(hwrite[1]),
    .M1_HWDATA_I(hwdata[1]), .M1_HRDATA_O(hrdata[1]), .M1_HREADY_O(hready[1]), .M1_HRESP_O(hresp[1]),
    .S_HSEL_O(S_HSEL_O), .S_HREADY_O(S_HREADY_O), .S_HADDR_O(S_HADDR_O), .S_HSIZE_O(S_HSIZE_O),
    .S_HWRITE_O(S_HWRITE_O), .S_HWDATA_O(S_HWDATA_O), .S_HRDATA_I(s_hrdata),
    .S_HREADY_I(s_hready), .S_HRESP_I(s_hresp), .DBG_DP_OWNER_O(dbg_owner)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    HCLK_I = 1'b0;
    forever #5 HCLK_I = ~HCLK_I;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Little-endian byte-lane merge of a write into a 32-bit word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [7:0] a, input logic [2:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s == HSIZE_WORD || (s == HSIZE_HALF && (b / 2) == int'(a[1])) ||
          (s == HSIZE_BYTE && b == int'(a[1:0])))
        r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // ---------------- RAM slave model ----------------
  logic [31:0] mem [64];
  logic        ram_dv, ram_w;
  logic [7:0]  ram_a;
  logic [2:0]  ram_s;

  always @(posedge HCLK_I or posedge HRESET_I) begin
    if (HRESET_I) begin
      ram_dv <= 1'b0;
      ram_w  <= 1'b0;
      ram_a  <= 8'd0;
      ram_s  <= 3'd0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    end else begin
      if (ram_dv && s_hready && ram_w) mem[ram_a[7:2]] <= merge(mem[ram_a[7:2]], S_HWDATA_O, ram_a, ram_s);
      if (S_HSEL_O && S_HREADY_O) begin
        ram_dv <= 1'b1;
        ram_a  <= S_HADDR_O;
        ram_s  <= S_HSIZE_O;
        ram_w  <= S_HWRITE_O;
      end else if (s_hready) begin
        ram_dv <= 1'b0;
      end
    end
  end

  assign s_hrdata = mem[ram_a[7:2]];

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge HCLK_I);
    #1;
  endtask

  task automatic req(input int m, input logic [7:0] a, input logic [2:0] s, input logic w);
    htrans[m] = HTRANS_NONSEQ;
    haddr[m]  = a;
    hsize[m]  = s;
    hwrite[m] = w;
  endtask

  task automatic idle(input int m);
    htrans[m] = HTRANS_IDLE;
  endtask

  // Both masters request together: M0 reads 0x20, M1 writes byte 0xA5 @0x21.
  task automatic contend(input int w, input logic a5_before);
    tick(); req(0, 8'h20, HSIZE_WORD, 1'b0); req(1, 8'h21, HSIZE_BYTE, 1'b1); #1;
    check("cont_hsel", 32'(S_HSEL_O), 1);
    check("cont_first_addr", 32'(S_HADDR_O), (w == 1) ? 32'h21 : 32'h20);
    check("cont_acc_m0", 32'(hready[0]), 1);
    check("cont_acc_m1", 32'(hready[1]), 1);
    tick(); idle(0); idle(1); if (w == 1) hwdata[1] = 32'h0000A500; #1;
    check("cont_second_addr", 32'(S_HADDR_O), (w == 1) ? 32'h20 : 32'h21);
    check("cont_loser_wait", 32'(hready[1-w]), 0);
    check("cont_winner_done", 32'(hready[w]), 1);
    if (w == 0) check("cont_rd_first", hrdata[0], a5_before ? 32'h0000A500 : 32'h0);
    tick(); if (w == 0) hwdata[1] = 32'h0000A500; #1;
    check("cont_loser_done", 32'(hready[1-w]), 1);
    if (w == 1) check("cont_rd_after_wr", hrdata[0], 32'h0000A500);
  endtask

  // Pipelined random master confined to its own 64-byte region.
  task automatic master_run(input int m, input int n);
    int issued, done, waits;
    logic ap_v, dp_v, ap_w, dp_w;
    logic [7:0] ap_a, dp_a, off, base;
    logic [2:0] ap_s, dp_s;
    logic [31:0] dp_d;
    issued = 0; done = 0; waits = 0;
    ap_v = 0; dp_v = 0; ap_w = 0; dp_w = 0; ap_a = 0; dp_a = 0; ap_s = 0; dp_s = 0; dp_d = 0;
    base = (m == 1) ? 8'hC0 : 8'h80;
    while (done < n) begin
      @(negedge HCLK_I); #2;
      if (!hready[m]) begin
        waits++;
        if (waits > 60) begin
          check(m == 1 ? "rand_timeout_m1" : "rand_timeout_m0", 32'(waits), 0);
          return;
        end
        continue;
      end
      waits = 0;
      if (dp_v) begin
        if (dp_w) ref_mem[dp_a[7:2]] = merge(ref_mem[dp_a[7:2]], dp_d, dp_a, dp_s);
        else check(m == 1 ? "rand_rd_m1" : "rand_rd_m0", hrdata[m], ref_mem[dp_a[7:2]]);
        done++;
      end
      dp_v = ap_v; dp_a = ap_a; dp_s = ap_s; dp_w = ap_w; dp_d = $urandom;
      ap_v = (issued < n) && ($urandom_range(9) < 7);
      if (ap_v) begin
        issued++;
        ap_s = 3'($urandom_range(2));
        off  = 8'($urandom_range(63));
        if (ap_s == HSIZE_HALF) off[0] = 1'b0;
        if (ap_s == HSIZE_WORD) off[1:0] = 2'b00;
        ap_a = base | off;
        ap_w = 1'($urandom_range(1));
      end
      @(posedge HCLK_I); #1;
      htrans[m] = ap_v ? HTRANS_NONSEQ : HTRANS_IDLE;
      haddr[m]  = ap_a;
      hsize[m]  = ap_s;
      hwrite[m] = ap_w;
      hwdata[m] = dp_d;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    logic rr_last_m1;
    logic rand_active;
    HRESET_I = 1'b1; s_hready = 1'b1; s_hresp = 1'b0;
    for (int m = 0; m < 2; m++) begin
      idle(m); haddr[m] = 0; hsize[m] = 0; hwrite[m] = 0; hwdata[m] = 0;
    end
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    req(1, 8'h30, HSIZE_WORD, 1'b1);
    repeat (2) @(posedge HCLK_I);
    #2;
    check("rst_m0_ready", 32'(hready[0]), 1);
    check("rst_m1_ready", 32'(hready[1]), 1);
    check("rst_sel", 32'(S_HSEL_O), 0);
    check("rst_resp", {30'd0, hresp[1], hresp[0]}, 0);
    check("rst_owner", 32'(dbg_owner), 0);

    // Reset in the middle of an M1 write data phase.
    tick(); HRESET_I = 1'b0; #1;
    check("m1_wr_sel", 32'(S_HSEL_O), 1);
    tick(); idle(1); hwdata[1] = 32'h11223344; #1;
    check("m1_wr_hwdata", S_HWDATA_O, 32'h11223344);
    HRESET_I = 1'b1; #1;
    check("midrst_m0_ready", 32'(hready[0]), 1);
    check("midrst_m1_ready", 32'(hready[1]), 1);
    check("midrst_sel", 32'(S_HSEL_O), 0);
    tick(); HRESET_I = 1'b0; req(0, 8'h30, HSIZE_WORD, 1'b0); #1;
    tick(); idle(0); #1;
    check("midrst_no_write", hrdata[0], 32'h0);
    rr_last_m1 = 1'b1;

    // Uncontended: M1 writes 0xDEADBEEF @0x10, then M0 reads it with no wait state.
    tick(); req(1, 8'h10, HSIZE_WORD, 1'b1); #1;
    check("pre_addr", 32'(S_HADDR_O), 32'h10);
    tick(); idle(1); hwdata[1] = 32'hDEADBEEF; req(0, 8'h10, HSIZE_WORD, 1'b0); #1;
    check("m0_rd_sel", 32'(S_HSEL_O), 1);
    check("m0_rd_write", 32'(S_HWRITE_O), 0);
    tick(); idle(0); #1;
    check("m0_rd_ready", 32'(hready[0]), 1);
    check("m0_rd_data", hrdata[0], 32'hDEADBEEF);

    // Contention twice: fixed priority always M1, round-robin alternates.
    for (int rep = 0; rep < 2; rep++) begin
`ifdef RAMARB_RR_EN
      w = rr_last_m1 ? 0 : 1;
`else
      w = 1;
`endif
      contend(w, rep > 0);
      rr_last_m1 = (w == 1);
    end

`ifndef RAMARB_RR_EN
    // M1 streams 10 writes; M0 is held off until the stream ends.
    tick(); req(0, 8'h44, HSIZE_WORD, 1'b0); req(1, 8'h48, HSIZE_WORD, 1'b1); #1;
    check("starve_first_m1", 32'(S_HADDR_O), 32'h48);
    for (int k = 1; k < 10; k++) begin
      tick(); idle(0); hwdata[1] = 32'(k); #1;
      check("starve_m0_wait", 32'(hready[0]), 0);
    end
    tick(); idle(1); hwdata[1] = 32'd10; #1;
    check("starve_m0_issue", 32'(S_HADDR_O), 32'h44);
    check("starve_m0_still", 32'(hready[0]), 0);
    tick(); #1;
    check("starve_m0_done", 32'(hready[0]), 1);
    check("starve_m0_data", hrdata[0], 32'h0);
`endif

    // RAM wait states during an M0 read while M1 requests.
    tick(); req(0, 8'h40, HSIZE_WORD, 1'b0); #1;
    tick(); idle(0); req(1, 8'h4C, HSIZE_WORD, 1'b0); s_hready = 1'b0; #1;
    check("stall_sel1", 32'(S_HSEL_O), 0);
    check("stall_m0_w1", 32'(hready[0]), 0);
    check("stall_m1_acc", 32'(hready[1]), 1);
    tick(); idle(1); #1;
    check("stall_sel2", 32'(S_HSEL_O), 0);
    check("stall_m0_w2", 32'(hready[0]), 0);
    check("stall_m1_w2", 32'(hready[1]), 0);
    tick(); s_hready = 1'b1; #1;
    check("stall_m0_done", 32'(hready[0]), 1);
    check("stall_m1_issue", 32'(S_HADDR_O), 32'h4C);
    tick(); #1;
    check("stall_m1_done", 32'(hready[1]), 1);

    // Halfword write 0x1234 @0x06 and readback.
    tick(); req(0, 8'h06, HSIZE_HALF, 1'b1); #1;
    check("hw_size", 32'(S_HSIZE_O), 1);
    check("hw_addr", 32'(S_HADDR_O), 32'h06);
    tick(); idle(0); hwdata[0] = 32'h12340000; #1;
    check("hw_hwdata", S_HWDATA_O, 32'h12340000);
    tick(); req(0, 8'h04, HSIZE_WORD, 1'b0); #1;
    tick(); idle(0); #1;
    check("hw_readback", {16'd0, hrdata[0][31:16]}, 32'h1234);

    // Error response is forwarded only to the data-phase owner.
    tick(); req(1, 8'h50, HSIZE_WORD, 1'b0); #1;
    tick(); idle(1); s_hresp = 1'b1; #1;
    check("resp_m1", 32'(hresp[1]), 1);
    check("resp_m0", 32'(hresp[0]), 0);
    tick(); s_hresp = 1'b0; #1;
    tick();

    // Randomized traffic from both masters with random RAM wait states.
    rand_active = 1'b1;
    fork
      begin
        fork
          master_run(0, 80);
          master_run(1, 80);
        join
        rand_active = 1'b0;
      end
      begin
        while (rand_active) begin
          @(negedge HCLK_I);
          s_hready = ($urandom_range(4) != 0);
        end
        s_hready = 1'b1;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
